// File: rtl/alarm_clock_pio_irq_ctrl.sv
// Key-PIO interrupt service: writes the IRQ mask, reads/clears edge capture, queues one event per key.
// Latency: irq in IDLE cycle T -> first PUSH at T+4, ev_valid at T+5; service takes 4 + popcount(cap) cycles.
// Backpressure: ev_valid/ev_ready FIFO; a push into a full FIFO without a same-cycle pop is dropped and sets overflow.
// Optional feature: define ALARM_PIO_CTRL_LOCKOUT_EN for the per-key re-trigger lockout.

// Small generic FIFO: a push into a full FIFO is accepted only when a pop happens in the same cycle.
module alarm_clock_pio_irq_ctrl_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign out_vld = (count != '0);
  assign out_dat = mem[rd_ptr];
  assign do_pop  = out_vld & out_rdy;
  assign in_rdy  = ~full | do_pop;
  assign do_push = in_vld & in_rdy;

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 while empty after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module alarm_clock_pio_irq_ctrl #(
  parameter logic [3:0] MASK_INIT      = 4'hF,
  parameter int         FIFO_DEPTH     = 4,
  parameter int         LOCKOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic [3:0]  cfg_mask,
  input  logic        cfg_mask_wr,
  output logic        ev_valid,
  output logic [1:0]  ev_key,
  input  logic        ev_ready,
  output logic        overflow,
  input  logic        overflow_clr,
  output logic        busy
);
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_WAIT, S_CLR, S_PUSH, S_CFG} state_t;

  state_t      state, state_d;
  logic [3:0]  cap;
  logic [3:0]  cap_rest;
  logic [3:0]  mask_q;
  logic        mask_pend;
  logic        push_req;
  logic        push_en;
  logic [1:0]  push_key;
  logic        fifo_in_rdy;
  logic [27:0] unused_rd;

  // Only the four capture bits of the PIO read are meaningful.
  assign unused_rd = m_readdata[31:4];
  assign busy      = (state != S_IDLE);
  assign cap_rest  = cap & (cap - 4'd1);

  // Lowest set capture bit is serviced first.
  always_comb begin
    push_key = 2'd3;
    if (cap[0])      push_key = 2'd0;
    else if (cap[1]) push_key = 2'd1;
    else if (cap[2]) push_key = 2'd2;
  end

  // Next-state and Avalon master outputs; bus is forced idle while reset is asserted.
  always_comb begin
    state_d      = state;
    m_address    = 2'd0;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_writedata  = 32'd0;
    push_req     = 1'b0;
    case (state)
      S_INIT: begin
        m_address    = 2'd2;
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_writedata  = {28'd0, MASK_INIT};
        state_d      = S_IDLE;
      end
      S_IDLE: begin
        if (mask_pend || cfg_mask_wr) state_d = S_CFG;
        else if (irq)                 state_d = S_RD;
      end
      S_CFG: begin
        m_address    = 2'd2;
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_writedata  = {28'd0, mask_q};
        state_d      = S_IDLE;
      end
      S_RD: begin
        m_address    = 2'd3;
        m_chipselect = 1'b1;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        state_d = (m_readdata[3:0] == 4'd0) ? S_IDLE : S_CLR;
      end
      S_CLR: begin
        m_address    = 2'd3;
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        state_d      = S_PUSH;
      end
      S_PUSH: begin
        push_req = (cap != 4'd0);
        if (cap_rest == 4'd0) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
    if (reset) begin
      m_address    = 2'd0;
      m_chipselect = 1'b0;
      m_write_n    = 1'b1;
      m_writedata  = 32'd0;
    end
  end

  // State register, capture latch and pending mask request (a new request beats the CFG clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_INIT;
      cap       <= 4'd0;
      mask_q    <= 4'd0;
      mask_pend <= 1'b0;
    end else begin
      state <= state_d;
      if (state == S_WAIT)      cap <= m_readdata[3:0];
      else if (state == S_PUSH) cap <= cap_rest;
      if (cfg_mask_wr) begin
        mask_q    <= cfg_mask;
        mask_pend <= 1'b1;
      end else if (state == S_CFG) begin
        mask_pend <= 1'b0;
      end
    end
  end

`ifdef ALARM_PIO_CTRL_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  logic [LW-1:0] lock_cnt [4];

  assign push_en = push_req && (lock_cnt[push_key] == '0);

  // Every PUSH for a key (kept or discarded) restarts its lockout window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) lock_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push_req && (push_key == 2'(k))) lock_cnt[k] <= LW'(LOCKOUT_CYCLES);
        else if (lock_cnt[k] != '0)          lock_cnt[k] <= lock_cnt[k] - LW'(1);
      end
    end
  end
`else
  localparam int unused_lockout = LOCKOUT_CYCLES;
  assign push_en = push_req;
`endif

  alarm_clock_pio_irq_ctrl_fifo #(.W(2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (push_en),
    .in_dat  (push_key),
    .in_rdy  (fifo_in_rdy),
    .out_vld (ev_valid),
    .out_dat (ev_key),
    .out_rdy (ev_ready)
  );

  // Sticky drop flag; an explicit clear wins over a same-cycle drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       overflow <= 1'b0;
    else if (overflow_clr)           overflow <= 1'b0;
    else if (push_en && !fifo_in_rdy) overflow <= 1'b1;
  end
endmodule

// File: tb/tb_alarm_clock_pio_irq_ctrl.sv
// Directed bench for alarm_clock_pio_irq_ctrl with a small behavioural model of the key PIO.
// Inputs change on the falling edge, outputs are sampled there too (or 1 time unit after it).
// Each scenario task checks its own expectations inline.
module tb_alarm_clock_pio_irq_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        irq;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = 32'd0;
  logic [3:0]  cfg_mask = 4'd0;
  logic        cfg_mask_wr = 1'b0;
  logic        ev_valid;
  logic [1:0]  ev_key;
  logic        ev_ready = 1'b0;
  logic        overflow;
  logic        overflow_clr = 1'b0;
  logic        busy;

  // PIO model state
  logic [3:0]  ecap = 4'd0;
  logic [3:0]  pio_mask = 4'd0;
  logic [3:0]  inj = 4'd0;
  logic        irq_force = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign irq = (|(ecap & pio_mask)) | irq_force;

  // PIO: registered read data, edge-capture clear on write to address 3, mask at address 2.
  always @(posedge clk) begin
    case (m_address)
      2'd2:    m_readdata <= {28'd0, pio_mask};
      2'd3:    m_readdata <= {28'd0, ecap};
      default: m_readdata <= 32'd0;
    endcase
    if (m_chipselect && !m_write_n && m_address == 2'd3) ecap <= inj;
    else                                                 ecap <= ecap | inj;
    if (m_chipselect && !m_write_n && m_address == 2'd2) pio_mask <= m_writedata[3:0];
  end

  alarm_clock_pio_irq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .cfg_mask     (cfg_mask),
    .cfg_mask_wr  (cfg_mask_wr),
    .ev_valid     (ev_valid),
    .ev_key       (ev_key),
    .ev_ready     (ev_ready),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .busy         (busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) tick();
    vectors++;
    if ({busy, ev_valid, ev_key, overflow} !== 5'b1_0_00_0) begin
      miscompares++;
      $display("FAIL reset_status busy/valid/key/ovf got %b want 10000", {busy, ev_valid, ev_key, overflow});
    end
    vectors++;
    if ({m_chipselect, m_write_n, m_address, m_writedata} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_bus cs=%b wn=%b addr=%0d wdata=%h want cs=0 wn=1 addr=0 wdata=0",
               m_chipselect, m_write_n, m_address, m_writedata);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({m_chipselect, m_write_n, m_address, m_writedata} !== {1'b1, 1'b0, 2'd2, 32'h0000000F}) begin
      miscompares++;
      $display("FAIL init_write cs=%b wn=%b addr=%0d wdata=%h want cs=1 wn=0 addr=2 wdata=0000000f",
               m_chipselect, m_write_n, m_address, m_writedata);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || m_chipselect !== 1'b0) begin
      miscompares++;
      $display("FAIL init_to_idle busy=%b cs=%b want busy=0 cs=0", busy, m_chipselect);
    end
  endtask

  task automatic test_single_key();
    inj = 4'b0100;
    tick();                       // cycle T: irq high, DUT in IDLE
    inj = 4'b0000;
    tick();                       // T+1
    vectors++;
    if ({m_chipselect, m_write_n, m_address} !== {1'b1, 1'b1, 2'd3}) begin
      miscompares++;
      $display("FAIL single_rd cs=%b wn=%b addr=%0d want cs=1 wn=1 addr=3", m_chipselect, m_write_n, m_address);
    end
    tick();                       // T+2 WAIT
    vectors++;
    if ({m_chipselect, m_write_n, busy} !== 3'b011) begin
      miscompares++;
      $display("FAIL single_wait cs=%b wn=%b busy=%b want 0 1 1", m_chipselect, m_write_n, busy);
    end
    tick();                       // T+3 CLR
    vectors++;
    if ({m_chipselect, m_write_n, m_address, m_writedata} !== {1'b1, 1'b0, 2'd3, 32'd0}) begin
      miscompares++;
      $display("FAIL single_clr cs=%b wn=%b addr=%0d wdata=%h want cs=1 wn=0 addr=3 wdata=0",
               m_chipselect, m_write_n, m_address, m_writedata);
    end
    tick();                       // T+4 PUSH
    vectors++;
    if (ev_valid !== 1'b0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL single_push ev_valid=%b irq=%b want 0 0", ev_valid, irq);
    end
    tick();                       // T+5
    vectors++;
    if ({ev_valid, ev_key, busy} !== {1'b1, 2'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL single_event valid=%b key=%0d busy=%b want valid=1 key=2 busy=0", ev_valid, ev_key, busy);
    end
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    vectors++;
    if (ev_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pop ev_valid=%b want 0", ev_valid);
    end
  endtask

  task automatic test_multi_key();
    inj = 4'b1011;
    tick();                       // T
    inj = 4'b0000;
    ev_ready = 1'b1;
    repeat (5) tick();            // T+5
    vectors++;
    if ({ev_valid, ev_key} !== {1'b1, 2'd0}) begin
      miscompares++;
      $display("FAIL multi_ev0 valid=%b key=%0d want 1 0", ev_valid, ev_key);
    end
    tick();                       // T+6
    vectors++;
    if ({ev_valid, ev_key, busy} !== {1'b1, 2'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL multi_ev1 valid=%b key=%0d busy=%b want 1 1 1", ev_valid, ev_key, busy);
    end
    tick();                       // T+7
    vectors++;
    if ({ev_valid, ev_key, busy} !== {1'b1, 2'd3, 1'b0}) begin
      miscompares++;
      $display("FAIL multi_ev3 valid=%b key=%0d busy=%b want 1 3 0", ev_valid, ev_key, busy);
    end
    tick();
    vectors++;
    if (ev_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL multi_drained ev_valid=%b want 0", ev_valid);
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_spurious();
    irq_force = 1'b1;             // T: irq without any captured edge
    tick();                       // T+1 RD
    irq_force = 1'b0;
    tick();                       // T+2 WAIT reads 0
    tick();                       // T+3
    vectors++;
    if ({busy, m_chipselect, ev_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL spurious busy=%b cs=%b valid=%b want 0 0 0", busy, m_chipselect, ev_valid);
    end
  endtask

  task automatic test_overflow();
    logic [1:0] exp_k [4];
    exp_k[0] = 2'd0; exp_k[1] = 2'd1; exp_k[2] = 2'd2; exp_k[3] = 2'd0;
    inj = 4'b0111;
    tick();
    inj = 4'b0000;
    repeat (7) tick();
    vectors++;
    if ({busy, overflow} !== 2'b00) begin
      miscompares++;
      $display("FAIL ovf_first busy=%b overflow=%b want 0 0", busy, overflow);
    end
    inj = 4'b0011;
    tick();
    inj = 4'b0000;
    repeat (6) tick();
    vectors++;
    if ({busy, overflow, ev_valid, ev_key} !== {1'b0, 1'b1, 1'b1, 2'd0}) begin
      miscompares++;
      $display("FAIL ovf_set busy=%b overflow=%b valid=%b key=%0d want 0 1 1 0", busy, overflow, ev_valid, ev_key);
    end
    tick();
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_sticky overflow=%b want 1", overflow);
    end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear overflow=%b want 0", overflow);
    end
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({ev_valid, ev_key} !== {1'b1, exp_k[i]}) begin
        miscompares++;
        $display("FAIL ovf_drain%0d valid=%b key=%0d want 1 %0d", i, ev_valid, ev_key, exp_k[i]);
      end
      tick();
    end
    vectors++;
    if (ev_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_empty ev_valid=%b want 0", ev_valid);
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_cfg_priority();
    inj = 4'b0001;
    tick();                       // T: irq rises, mask request arrives
    inj = 4'b0000;
    cfg_mask = 4'h3;
    cfg_mask_wr = 1'b1;
    tick();                       // T+1
    cfg_mask_wr = 1'b0;
    vectors++;
    if ({m_chipselect, m_write_n, m_address, m_writedata} !== {1'b1, 1'b0, 2'd2, 32'h3}) begin
      miscompares++;
      $display("FAIL cfg_write cs=%b wn=%b addr=%0d wdata=%h want cs=1 wn=0 addr=2 wdata=3",
               m_chipselect, m_write_n, m_address, m_writedata);
    end
    tick();                       // T+2 IDLE
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_idle busy=%b want 0", busy);
    end
    tick();                       // T+3 RD
    vectors++;
    if ({m_chipselect, m_write_n, m_address} !== {1'b1, 1'b1, 2'd3}) begin
      miscompares++;
      $display("FAIL cfg_then_rd cs=%b wn=%b addr=%0d want 1 1 3", m_chipselect, m_write_n, m_address);
    end
    repeat (4) tick();            // T+7
    vectors++;
    if ({ev_valid, ev_key, busy} !== {1'b1, 2'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL cfg_event valid=%b key=%0d busy=%b want 1 0 0", ev_valid, ev_key, busy);
    end
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
  endtask

  task automatic test_lockout();
    int events;
    int exp_events;
`ifdef ALARM_PIO_CTRL_LOCKOUT_EN
    exp_events = 1;
`else
    exp_events = 2;
`endif
    events = 0;
    ev_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      inj = (i == 0 || i == 10) ? 4'b0001 : 4'b0000;
      tick();
      if (ev_valid === 1'b1) events++;
    end
    inj = 4'b0000;
    ev_ready = 1'b0;
    vectors++;
    if (events !== exp_events) begin
      miscompares++;
      $display("FAIL lockout_events got %0d want %0d", events, exp_events);
    end
  endtask

  task automatic test_midop_reset();
    int events;
    inj = 4'b0010;
    tick();                       // T
    inj = 4'b0000;
    tick();                       // T+1 RD
    tick();                       // T+2 WAIT
    reset = 1'b1;
    #1;
    vectors++;
    if ({busy, m_chipselect, ev_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL midrst_abort busy=%b cs=%b valid=%b want 1 0 0", busy, m_chipselect, ev_valid);
    end
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if ({m_chipselect, m_write_n, m_address, m_writedata} !== {1'b1, 1'b0, 2'd2, 32'h0000000F}) begin
      miscompares++;
      $display("FAIL midrst_init cs=%b wn=%b addr=%0d wdata=%h want 1 0 2 0000000f",
               m_chipselect, m_write_n, m_address, m_writedata);
    end
    // The uncleared capture is serviced after the re-init.
    events = 0;
    ev_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ev_valid === 1'b1 && ev_key === 2'd1) events++;
    end
    ev_ready = 1'b0;
    vectors++;
    if (events !== 1) begin
      miscompares++;
      $display("FAIL midrst_reservice key1 events got %0d want 1", events);
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_multi_key();
    test_spurious();
    test_overflow();
    test_cfg_priority();
    test_lockout();
    test_midop_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alarm_clock_pio_irq_ctrl.md
# alarm_clock_pio_irq_ctrl

Interrupt-service controller for the 4-bit key input PIO of the AlarmClock system. It drives the PIO's Avalon-MM slave port as a master: it writes the IRQ mask after reset and on request, and on PIO `irq` it reads and clears the edge-capture register. It then queues one event per captured key into a small FIFO for downstream alarm/time-set logic, so that logic no longer needs a CPU to poll the PIO.

## Interface
- `MASK_INIT`, 4'hF, IRQ mask written to PIO address 2 after reset.
- `FIFO_DEPTH`, 4, event FIFO entries; power of two, 2..16.
- `LOCKOUT_CYCLES`, 16, per-key re-trigger lockout length; used only with the macro below.
- `clk` in 1: single clock; all logic rising-edge.
- `reset` in 1: asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `irq` in 1: PIO interrupt, level.
- `m_address` out 2: PIO register address.
- `m_chipselect` out 1: PIO select.
- `m_write_n` out 1: PIO write strobe, active-low.
- `m_writedata` out 32: PIO write data.
- `m_readdata` in 32: PIO read data. Registered in the PIO: it reflects the address presented one cycle earlier.
- `cfg_mask` in 4: new IRQ mask.
- `cfg_mask_wr` in 1: one-cycle request to write `cfg_mask`.
- `ev_valid` out 1: FIFO head valid.
- `ev_key` out 2: key index of the FIFO head.
- `ev_ready` in 1: consumer accepts the head.
- `overflow` out 1: sticky flag, event dropped because the FIFO was full.
- `overflow_clr` in 1: clears `overflow`.
- `busy` out 1: FSM not in IDLE.

## Operation
- FSM states: INIT, IDLE, RD, WAIT, CLR, PUSH, CFG.
- Bus idle outputs (IDLE, WAIT, PUSH): `m_chipselect`=0, `m_write_n`=1, `m_address`=0, `m_writedata`=0.
- INIT: write `MASK_INIT` to address 2 for one cycle. Then go to IDLE.
- IDLE priority order:
  - A pending mask write goes to CFG.
  - Otherwise `irq`=1 goes to RD.
  - Otherwise stay in IDLE.
- CFG: write the latched mask to address 2 for one cycle, clear the pending flag, then go to IDLE.
- `cfg_mask_wr` in any state sets the pending flag and latches `cfg_mask`. If several requests arrive before service, the last one wins.
- RD: `m_address`=3, `m_chipselect`=1, `m_write_n`=1 for one cycle. Then go to WAIT.
- WAIT: latch `m_readdata[3:0]` into `cap`.
  - If `cap`==0 (spurious), go to IDLE.
  - Otherwise go to CLR.
- CLR: write 0 to address 3 for one cycle. The PIO clears all four capture bits. Then go to PUSH.
- PUSH: one cycle per set bit of `cap`, lowest index first. Each cycle pushes the index and clears that bit. When `cap`==0, go to IDLE.
- An edge that the PIO captures during the RD..CLR window is lost. This is accepted and documented behaviour.
- FIFO:
  - Pop when `ev_valid & ev_ready`.
  - A push while full is accepted only if a pop happens in the same cycle. Otherwise the event is dropped and `overflow` is set.
  - `overflow_clr` takes precedence over a same-cycle set.
- Reset values: FSM=INIT; FIFO empty; `ev_valid`=0, `ev_key`=0, `overflow`=0, `busy`=1; bus outputs at idle values. Reset asserted mid-operation aborts the operation and discards its captured state. INIT re-runs on the first cycle after release.

## Timing
- Reset release: INIT write occurs in cycle 0, IDLE is reached in cycle 1.
- `irq` high in IDLE cycle T:
  - RD in T+1.
  - WAIT in T+2 (latch at the end of T+2).
  - CLR in T+3.
  - First PUSH in T+4.
  - `ev_valid`=1 from T+5 if the FIFO was empty.
- PIO `irq` falls at the end of T+3, so IDLE never re-enters RD for an already-serviced capture.
- Service time: 4 + popcount(`cap`) cycles, IDLE to IDLE.

## Configuration
- `ALARM_PIO_CTRL_LOCKOUT_EN` defined:
  - Each key has a counter of width clog2(`LOCKOUT_CYCLES`+1).
  - A PUSH for a key loads its counter with `LOCKOUT_CYCLES`. Counters decrement to 0, one per cycle.
  - A PUSH for a key with a nonzero counter is discarded silently: no FIFO write and no `overflow`. It still takes its PUSH cycle.
- Macro undefined: no counters; every captured key is pushed.

## Test plan
- Reset release → cycle 0: `m_address`=2, `m_chipselect`=1, `m_write_n`=0, `m_writedata`=0x0000000F; cycle 1: `busy`=0.
- PIO `edge_capture`=4'b0100, `irq` high at T → RD at T+1, CLR write to address 3 at T+3, `ev_valid`=1 with `ev_key`=2 at T+5.
- `cap`=4'b1011 with `ev_ready`=1 → `ev_key` sequence 0, 1, 3 on consecutive cycles; IDLE after 7 cycles.
- `ev_ready`=0, `FIFO_DEPTH`=4, two services with `cap`=4'b0111 then 4'b0011 → 4 events held, `overflow`=1; `overflow_clr` pulse → `overflow`=0.
- `cfg_mask_wr` with `cfg_mask`=4'h3 in the same cycle `irq` rises in IDLE → CFG write of 0x3 to address 2 first, then RD.
- Macro defined, `LOCKOUT_CYCLES`=16, key 0 captured twice 10 cycles apart → exactly one event. Macro undefined → two events.
